// File: rtl/smg_pkg.sv
// Shared types and constants for the 4-digit seven-segment display controller.
// Build option: SMG_BLANK_LEADING_EN blanks the top index digit while it is zero.
package smg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_LOAD
    } fetch_state_e;

    localparam int NUM_DIGITS = 4;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {g,f,e,d,c,b,a}, entry 0 in the low bits.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/smg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module smg_hex_decode
    import smg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = HEX_SEG[nibble];

endmodule

// File: rtl/smg_disp_ctrl.sv
// FIFO-fed byte fetcher with a multiplexed 4-digit hex display (index.data).
// Build option: SMG_BLANK_LEADING_EN blanks digit3 while idx_q[7:4] is zero.
module smg_disp_ctrl
    import smg_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic       clk_50MHz,
    input  logic       rst,
    input  logic       scan_tick,
    input  logic       next_tick,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rdata,
    output logic       fifo_rd,
    output logic [7:0] seg,
    output logic [3:0] sel,
    output logic       underflow
);

    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 2);

    fetch_state_e state_q, state_d;
    logic       pend_q, pend_d;
    logic       underflow_q, underflow_d;
    logic [7:0] data_q, data_d;
    logic [7:0] idx_q, idx_d;
    logic [1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0] ptr_q, ptr_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic [7:0] seg_q, seg_d;
    logic       rd_c;
    logic [1:0] ptr_nxt;
    logic [3:0] nib_c;
    logic [6:0] hex_c;
    logic       blank_c;

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        underflow_d = underflow_q;
        data_d      = data_q;
        idx_d       = idx_q;
        wait_cnt_d  = wait_cnt_q;
        rd_c        = 1'b0;
        // A single request can be queued while a fetch is in flight.
        if (next_tick && state_q != ST_IDLE) begin
            pend_d = 1'b1;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (next_tick || pend_q) begin
                    pend_d = 1'b0;
                    if (fifo_empty) begin
                        underflow_d = 1'b1;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (fifo_empty) begin
                    state_d = ST_IDLE;
                end else begin
                    rd_c       = 1'b1;
                    wait_cnt_d = 2'd0;
                    state_d    = (RD_LAT == 1) ? ST_LOAD : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_LOAD;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            ST_LOAD: begin
                data_d  = fifo_rdata;
                idx_d   = idx_q + 8'd1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ptr_nxt = ptr_q + 2'd1;

    always_comb begin
        nib_c = data_q[3:0];
        unique case (ptr_nxt)
            2'd0: nib_c = data_q[3:0];
            2'd1: nib_c = data_q[7:4];
            2'd2: nib_c = idx_q[3:0];
            2'd3: nib_c = idx_q[7:4];
            default: nib_c = data_q[3:0];
        endcase
    end

    smg_hex_decode u_hex (
        .nibble (nib_c),
        .seg_n  (hex_c)
    );

`ifdef SMG_BLANK_LEADING_EN
    assign blank_c = (ptr_nxt == 2'd3) && (idx_q[7:4] == 4'h0);
`else
    assign blank_c = 1'b0;
`endif

    always_comb begin
        ptr_d = ptr_q;
        sel_d = sel_q;
        seg_d = seg_q;
        if (scan_tick) begin
            ptr_d = ptr_nxt;
            sel_d = ~(NUM_DIGITS'(1) << ptr_nxt);
            // Decimal point marks the boundary between index and data.
            seg_d = blank_c ? SEG_BLANK : {(ptr_nxt != 2'd2), hex_c};
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pend_q      <= 1'b0;
            underflow_q <= 1'b0;
            data_q      <= 8'h00;
            idx_q       <= 8'h00;
            wait_cnt_q  <= 2'd0;
            ptr_q       <= 2'd3;
            sel_q       <= '1;
            seg_q       <= SEG_BLANK;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            underflow_q <= underflow_d;
            data_q      <= data_d;
            idx_q       <= idx_d;
            wait_cnt_q  <= wait_cnt_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            seg_q       <= seg_d;
        end
    end

    assign fifo_rd   = rd_c & ~rst;
    assign seg       = seg_q;
    assign sel       = sel_q;
    assign underflow = underflow_q;

endmodule

// File: doc/smg_disp_ctrl.md
SMG_DISP_CTRL -- requirements
Module: smg_disp_ctrl

Interface
REQ-001 SHALL have parameter RD_LAT, default 1: FIFO read latency in clocks, from fifo_rd high to fifo_rdata valid (legal 1..3).
REQ-002 SHALL have port clk_50MHz, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port scan_tick, input, 1: 1 kHz single-cycle strobe that advances the digit scan.
REQ-005 SHALL have port next_tick, input, 1: single-cycle strobe that requests the next FIFO byte.
REQ-006 SHALL have port fifo_empty, input, 1: FIFO holds no data.
REQ-007 SHALL have port fifo_rdata, input, 8: FIFO read data.
REQ-008 SHALL have port fifo_rd, output, 1: single-cycle FIFO read strobe.
REQ-009 SHALL have port seg, output, 8: active-low segments {dp,g,f,e,d,c,b,a}.
REQ-010 SHALL have port sel, output, 4: active-low one-hot digit select; bit0 = rightmost digit.
REQ-011 SHALL have port underflow, output, 1: sticky flag, next_tick seen while FIFO empty.

Function
REQ-012 SHALL run a fetch FSM with states IDLE, READ, WAIT, LOAD.
REQ-013 SHALL move IDLE->READ when (next_tick or pend) and !fifo_empty, asserting fifo_rd for exactly the one READ cycle.
REQ-014 SHALL move READ->WAIT and stay in WAIT for RD_LAT-1 cycles (0 when RD_LAT=1), then go to LOAD.
REQ-015 SHALL, in LOAD, latch fifo_rdata into data_q, increment 8-bit idx_q (255 wraps to 0), then return to IDLE; total latency next_tick to data_q update = RD_LAT+2 clocks.
REQ-016 SHALL set a one-deep pend flag when next_tick arrives outside IDLE; further ticks while pend set are dropped; pend clears on IDLE->READ.
REQ-017 SHALL, on next_tick or pend in IDLE with fifo_empty=1, set underflow, clear pend, stay in IDLE, leave data_q/idx_q unchanged.
REQ-018 SHALL never assert fifo_rd while fifo_empty=1 in the same cycle.
REQ-019 SHALL keep a 2-bit digit pointer that increments on scan_tick, wrapping 3->0.
REQ-020 SHALL register sel and seg one clock after scan_tick; between scan_ticks they hold.
REQ-021 SHALL display digit0 = data_q[3:0], digit1 = data_q[7:4], digit2 = idx_q[3:0], digit3 = idx_q[7:4], hex 0-F.
REQ-022 SHALL drive dp low (lit) on digit2 only, separating index from data.
REQ-023 SHALL treat scan_tick and next_tick in the same cycle independently; neither is lost.

Reset
REQ-024 SHALL, while rst=1, force state IDLE, fifo_rd=0, pend=0, underflow=0, data_q=0, idx_q=0, pointer=3, sel=4'b1111, seg=8'hFF.
REQ-025 SHALL abandon any fetch when rst asserts mid-READ/WAIT/LOAD; returned FIFO data is discarded.
REQ-026 SHALL, after reset release, light digit0 on the clock following the first scan_tick.

Configuration
REQ-027 SHALL honour macro SMG_BLANK_LEADING_EN: when defined, digit3 shows blank (seg=8'hFF, dp off) while idx_q[7:4]=0; when undefined, digit3 always shows its hex value.

Structure
REQ-028 SHALL take from shared package smg_pkg: FSM state enum, 7-segment hex table constants, SEG_BLANK=8'hFF, NUM_DIGITS=4.
REQ-029 SHALL instantiate one combinational sub-module smg_hex_decode (4-bit nibble in, active-low 7-seg out).

Verification
REQ-030 SHALL test: reset, one scan_tick -> next clock sel=4'b1110, seg=8'hC0 ("0").
REQ-031 SHALL test: FIFO holds 8'hA5, next_tick, RD_LAT=1 -> fifo_rd high one cycle; 3 clocks later data_q=8'hA5, idx_q=1; digit1 shows "A" (seg=8'h88).
REQ-032 SHALL test: fifo_empty=1, next_tick -> fifo_rd stays 0, underflow=1 and holds until rst.
REQ-033 SHALL test: two next_ticks 1 clock apart, FIFO holds 8'h11, 8'h22 -> two reads back-to-back via pend; final data_q=8'h22, idx_q=2; third tick during fetch dropped.
REQ-034 SHALL test: idx_q=8'h05 -> digit3 seg=8'hFF with SMG_BLANK_LEADING_EN, seg=8'hC0 without.
REQ-035 SHALL test: rst pulsed during WAIT (RD_LAT=3) -> all outputs at reset values next clock; late fifo_rdata not latched.
